holo_column_sched: RTL and testbench
====================================

Name: holo_column_sched

Overview:
- Controller that sequences texture-column refreshes of the WS2812 strip on the spinning display.
- Watches the angle index and the revolution pulse, latches the column and active texture bank, and launches one strip frame per column change.
- Drives the texture ROM address for each pixel the strip requests, and returns the pixel data to the strip.
- Sits between the angle generator, the MMIO texture register, the texture ROM and the strip controller.

Parameters:
- LED_COUNT, 52, pixels per strip frame.
- TEX_WIDTH, 256, texture columns; power of two, at least 2^THETA_BITS.
- THETA_BITS, 6, width of the angle index.
- NUM_TEX, 4, number of texture banks stored back-to-back in the ROM.
- TEX_IDX_BITS, 4, width of the MMIO texture index.
- STALL_CYCLES, 50_000_000, stall timeout; used only with the optional feature.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- theta, in, THETA_BITS: current angle index.
- rev_pulse, in, 1: one-cycle pulse at each revolution start.
- tex_req_idx, in, TEX_IDX_BITS: requested texture bank.
- tex_req_valid, in, 1: one-cycle strobe that captures tex_req_idx.
- px_idx, in, 6: pixel index currently requested by the strip.
- strip_busy, in, 1: high while the strip is shifting a frame.
- strip_start, out, 1: one-cycle frame launch pulse.
- rom_addr, out, clog2(NUM_TEX*LED_COUNT*TEX_WIDTH): texture ROM address.
- rom_data, in, 24: ROM read data (1-cycle synchronous ROM).
- pixel_out, out, 24: GRB pixel to the strip.
- active_tex, out, TEX_IDX_BITS: bank currently displayed.
- tex_err, out, 1: sticky flag, set when a request is out of range.
- skip_count, out, 16: columns dropped because the strip was busy; saturating.
- rev_count, out, 16: revolutions seen; wraps.

Behaviour:
- Reset (async assert, sync release): state IDLE. strip_start=0, rom_addr=0, pixel_out=0, active_tex=0, tex_err=0, skip_count=0, rev_count=0. Pending-bank valid and column-pending flags cleared.
- Texture request:
  - tex_req_valid with tex_req_idx < NUM_TEX: the index goes to a pending register; a newer request overwrites an older one.
  - tex_req_idx >= NUM_TEX: request ignored and tex_err set.
  - A pending bank becomes active only at the first LAUNCH after a rev_pulse, so a bank switch never tears a revolution.
  - A request on the same cycle as rev_pulse applies to that same revolution.
- rev_count increments on every rev_pulse, in every state.
- FSM:
  - IDLE: wait for rev_pulse, then go to LAUNCH. No frames are launched before the first revolution.
  - WAIT: go to LAUNCH on rev_pulse, on theta != col_q, or when the column-pending flag is set.
  - LAUNCH (1 cycle): latch col_q = theta << (log2(TEX_WIDTH) - THETA_BITS), apply the pending bank if armed, clear the column-pending flag, assert strip_start for this cycle only, go to STREAM.
  - STREAM: wait for strip_busy to rise and then fall, then go to WAIT. If strip_busy has not risen within 4 cycles of LAUNCH, the frame is treated as complete and the FSM returns to WAIT.
- Column change during STREAM:
  - The first change sets the column-pending flag.
  - Each further distinct theta change while the flag is set increments skip_count, which saturates at 0xFFFF.
  - Only the latest theta is launched once the frame completes.
- Address: rom_addr = ((active_tex*LED_COUNT) + px_idx)*TEX_WIDTH + col_q, registered.
  - px_idx >= LED_COUNT is clamped to LED_COUNT-1.
  - col_q wraps naturally at TEX_WIDTH.
- Latency: px_idx to rom_addr is 1 cycle; rom_data to pixel_out is 1 cycle registered. px_idx to pixel_out is 3 cycles total; the strip controller must sample with this latency.
- Reset mid-STREAM: everything returns to IDLE immediately. strip_start stays low until the next rev_pulse.

Optional Feature:
- Macro: HOLO_STALL_BLANK_EN.
- Defined: a counter runs between rev_pulses. If it reaches STALL_CYCLES (motor stopped), the FSM goes to IDLE and pixel_out is forced to 0 until the next rev_pulse, which also clears the counter. This prevents a static column from burning one line.
- Undefined: no counter exists, the block never blanks, and STALL_CYCLES is unused.

Test Plan:
- Reset, then theta stepped 0 to 5 with no rev_pulse -> strip_start stays 0, state IDLE, all outputs 0.
- rev_pulse, then theta=3 with strip_busy high 10 cycles -> one strip_start pulse; col_q=12; px_idx=7 with active_tex=0 gives rom_addr=7*256+12=1804 one cycle later; pixel_out follows rom_data one cycle after that.
- tex_req_idx=2 strobed mid-revolution -> active_tex stays 0 until the next rev_pulse, then becomes 2; px_idx=0 at theta=0 gives rom_addr=2*52*256=26624. tex_req_idx=9 -> tex_err=1, active_tex unchanged.
- While in STREAM, theta goes 4,5,6 -> skip_count=1; the next launch uses col_q=24; exactly one extra strip_start.
- Reset asserted during STREAM -> immediate IDLE; strip_start held 0; skip_count and rev_count read 0.
- With HOLO_STALL_BLANK_EN and STALL_CYCLES=100, no rev_pulse for 100 cycles -> pixel_out=0 and state IDLE; the next rev_pulse resumes launches.

Source files
------------

// File: rtl/holo_column_sched_if.sv
// Strip-side and texture-ROM-side signals of the holographic column scheduler.
// master = scheduler, slave = strip controller plus texture ROM.
`timescale 1ns/1ps
interface holo_column_sched_if #(
  parameter int LED_COUNT = 52,
  parameter int TEX_WIDTH = 256,
  parameter int NUM_TEX   = 4
);
  localparam int ADDR_W = $clog2(NUM_TEX * LED_COUNT * TEX_WIDTH);

  logic [5:0]        px_idx;
  logic              strip_busy;
  logic              strip_start;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic [23:0]       pixel_out;

  modport master (
    input  px_idx, strip_busy, rom_data,
    output strip_start, rom_addr, pixel_out
  );

  modport slave (
    output px_idx, strip_busy, rom_data,
    input  strip_start, rom_addr, pixel_out
  );
endinterface

// File: rtl/holo_column_sched.sv
// Column refresh sequencer for the spinning WS2812 display: launches one strip frame per column change.
// Optional HOLO_STALL_BLANK_EN: blank the strip and idle when no revolution arrives within STALL_CYCLES.
`timescale 1ns/1ps
module holo_column_sched #(
  parameter int LED_COUNT    = 52,
  parameter int TEX_WIDTH    = 256,
  parameter int THETA_BITS   = 6,
  parameter int NUM_TEX      = 4,
  parameter int TEX_IDX_BITS = 4,
  parameter int STALL_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [THETA_BITS-1:0]   theta,
  input  logic                    rev_pulse,
  input  logic [TEX_IDX_BITS-1:0] tex_req_idx,
  input  logic                    tex_req_valid,
  holo_column_sched_if.master     strip,
  output logic [TEX_IDX_BITS-1:0] active_tex,
  output logic                    tex_err,
  output logic [15:0]             skip_count,
  output logic [15:0]             rev_count,
  output logic [1:0]              state_dbg
);

  localparam int COL_W  = $clog2(TEX_WIDTH);
  localparam int SHIFT  = COL_W - THETA_BITS;
  localparam int ADDR_W = $clog2(NUM_TEX * LED_COUNT * TEX_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    LAUNCH = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t state, state_next;

  logic [COL_W-1:0]        col_q;
  logic [THETA_BITS-1:0]   theta_prev;
  logic                    col_pend;
  logic                    rev_armed;
  logic                    pend_valid;
  logic [TEX_IDX_BITS-1:0] pend_idx;
  logic                    busy_seen;
  logic [2:0]              stream_cnt;
  logic [ADDR_W-1:0]       rom_addr_q;
  logic [23:0]             pixel_q;
  logic [5:0]              px_clamp;
  logic                    launch;
  logic                    req_ok;
  logic                    theta_moved;
  logic                    theta_step;
  logic                    stream_timeout;
  logic                    stall_hit;
  logic                    blank;

  // Handshake: strip_start is a one-cycle launch pulse (high only in LAUNCH). The strip answers
  // with strip_busy high for the whole frame and drops it when done; a frame whose strip_busy
  // never rises within 4 STREAM cycles is taken as already complete.
  assign launch         = (state == LAUNCH);
  assign req_ok         = tex_req_valid && (32'(tex_req_idx) < 32'(NUM_TEX));
  assign theta_moved    = (theta != col_q[COL_W-1 -: THETA_BITS]);
  assign theta_step     = (state == STREAM) && (theta != theta_prev);
  assign stream_timeout = !busy_seen && !strip.strip_busy && (stream_cnt == 3'd3);
  assign px_clamp       = (32'(strip.px_idx) >= 32'(LED_COUNT)) ? 6'(LED_COUNT - 1) : strip.px_idx;

  assign strip.strip_start = launch;
  assign strip.rom_addr    = rom_addr_q;
  assign strip.pixel_out   = pixel_q;
  assign state_dbg         = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (rev_pulse) state_next = LAUNCH;
      WAIT:    if (rev_pulse || rev_armed || col_pend || theta_moved) state_next = LAUNCH;
      LAUNCH:  state_next = STREAM;
      STREAM:  if ((busy_seen && !strip.strip_busy) || stream_timeout) state_next = WAIT;
      default: state_next = IDLE;
    endcase
    if (stall_hit && !rev_pulse) state_next = IDLE;
  end

  // Column latch, pending-column tracking and the dropped-column counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      theta_prev <= '0;
      col_pend   <= 1'b0;
      skip_count <= '0;
    end else begin
      theta_prev <= theta;
      if (launch) begin
        col_q    <= COL_W'(theta) << SHIFT;
        col_pend <= 1'b0;
      end else if (theta_step) begin
        if (!col_pend) col_pend <= 1'b1;
        else if (skip_count != 16'hFFFF) skip_count <= skip_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_seen  <= 1'b0;
      stream_cnt <= '0;
    end else if (launch) begin
      busy_seen  <= 1'b0;
      stream_cnt <= '0;
    end else if (state == STREAM) begin
      if (strip.strip_busy) busy_seen <= 1'b1;
      if (stream_cnt != 3'd7) stream_cnt <= stream_cnt + 3'd1;
    end
  end

  // A requested bank waits in pend_idx until the first launch of a new revolution.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      active_tex <= '0;
      tex_err    <= 1'b0;
      rev_armed  <= 1'b0;
      rev_count  <= '0;
    end else begin
      if (launch && rev_armed && pend_valid) begin
        active_tex <= pend_idx;
        pend_valid <= 1'b0;
      end
      if (req_ok) begin
        pend_idx   <= tex_req_idx;
        pend_valid <= 1'b1;
      end else if (tex_req_valid) begin
        tex_err <= 1'b1;
      end
      if (rev_pulse)   rev_armed <= 1'b1;
      else if (launch) rev_armed <= 1'b0;
      if (rev_pulse) rev_count <= rev_count + 16'd1;
    end
  end

  // Banks sit back-to-back, each one LED_COUNT rows of TEX_WIDTH columns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      pixel_q    <= '0;
    end else begin
      rom_addr_q <= ADDR_W'((32'(active_tex) * 32'(LED_COUNT) + 32'(px_clamp)) * 32'(TEX_WIDTH)
                            + 32'(col_q));
      pixel_q    <= blank ? 24'd0 : strip.rom_data;
    end
  end

`ifdef HOLO_STALL_BLANK_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic               blank_q;

  assign stall_hit = (stall_cnt == STALL_W'(STALL_CYCLES));
  assign blank     = blank_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (rev_pulse) begin
      stall_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (stall_hit) begin
      blank_q   <= 1'b1;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic stall_unused;

  assign stall_hit    = 1'b0;
  assign blank        = 1'b0;
  assign stall_unused = (STALL_CYCLES > 0);
`endif

endmodule

// File: tb/tb_holo_column_sched.sv
// Randomised bench for holo_column_sched against a transaction-level model of banks, columns and counters.
`timescale 1ns/1ps
module tb_holo_column_sched;
  localparam int LED  = 52;
  localparam int TEXW = 256;
  localparam int NTEX = 4;
`ifdef HOLO_STALL_BLANK_EN
  localparam int STALL = 300;
`else
  localparam int STALL = 1000;
`endif
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  theta = '0;
  logic        rev_pulse = 1'b0;
  logic [3:0]  tex_req_idx = '0;
  logic        tex_req_valid = 1'b0;
  logic [3:0]  active_tex;
  logic        tex_err;
  logic [15:0] skip_count, rev_count;
  logic [1:0]  state_dbg;

  holo_column_sched_if #(.LED_COUNT(LED), .TEX_WIDTH(TEXW), .NUM_TEX(NTEX)) bus ();

  holo_column_sched #(
    .LED_COUNT(LED), .TEX_WIDTH(TEXW), .THETA_BITS(6), .NUM_TEX(NTEX),
    .TEX_IDX_BITS(4), .STALL_CYCLES(STALL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .theta(theta), .rev_pulse(rev_pulse),
    .tex_req_idx(tex_req_idx), .tex_req_valid(tex_req_valid), .strip(bus),
    .active_tex(active_tex), .tex_err(tex_err), .skip_count(skip_count),
    .rev_count(rev_count), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // behavioural model state
  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int m_active = 0, m_pend = 0, m_pend_v = 0, m_err = 0, m_skip = 0, m_rev = 0, m_col = 0;
  logic [23:0] exp_q[$];

  function automatic logic [23:0] rom_fn(input logic [15:0] a);
    return {a[7:0] ^ a[15:8], a};
  endfunction

  function automatic int exp_addr(input int tex, input int px, input int th);
    int p;
    p = (px >= LED) ? LED - 1 : px;
    return (tex * LED + p) * TEXW + th * (TEXW / 64);
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  always begin
    @(posedge clk);
    #1;
    if (bus.strip_start === 1'b1) n_start++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] st, input int lim);
    for (int i = 0; i < lim && state_dbg !== st; i++) step(1);
  endtask

  task automatic strobe_req(input int idx);
    tex_req_idx   = 4'(idx);
    tex_req_valid = 1'b1;
    step(1);
    tex_req_valid = 1'b0;
    if (idx < NTEX) begin m_pend = idx; m_pend_v = 1; end
    else m_err = 1;
  endtask

  // busy_len > 0: frame of that length; 0: strip never answers; < 0: leave busy high and return.
  task automatic launch(input int th, input bit with_rev, input int busy_len, input int req);
    int s0;
    s0 = n_start;
    theta = 6'(th);
    rev_pulse = with_rev;
    if (req >= 0) begin tex_req_idx = 4'(req); tex_req_valid = 1'b1; end
    step(1);
    rev_pulse = 1'b0;
    tex_req_valid = 1'b0;
    if (req >= 0) begin
      if (req < NTEX) begin m_pend = req; m_pend_v = 1; end
      else m_err = 1;
    end
    if (with_rev) begin
      m_rev++;
      if (m_pend_v != 0) begin m_active = m_pend; m_pend_v = 0; end
    end
    m_col = th;
    n_checks++;
    if (bus.strip_start !== 1'b1) $display("FAIL launch_pulse: got %b want 1", bus.strip_start);
    else n_pass++;
    if (busy_len != 0) bus.strip_busy = 1'b1;
    if (busy_len >= 0) begin
      if (busy_len > 0) begin
        step(busy_len);
        bus.strip_busy = 1'b0;
      end
      wait_state(ST_WAIT, 20);
      n_checks++;
      if (state_dbg !== ST_WAIT) $display("FAIL frame_done: state %0d want %0d", state_dbg, ST_WAIT);
      else n_pass++;
      n_checks++;
      if (n_start - s0 !== 1) $display("FAIL one_start: got %0d starts want 1", n_start - s0);
      else n_pass++;
    end
  endtask

  task automatic probe(input int px, input string tag);
    int a, got;
    a = exp_addr(m_active, px, m_col);
    bus.px_idx = 6'(px);
    step(1);
    got = int'(bus.rom_addr);
    n_checks++;
    if (got !== a) $display("FAIL %s_addr: got %0d want %0d", tag, got, a);
    else n_pass++;
    exp_q.push_back(rom_fn(16'(a)));
    step(2);
    n_checks++;
    if (bus.pixel_out !== exp_q[0]) $display("FAIL %s_pixel: got %h want %h", tag, bus.pixel_out, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
  endtask

  function automatic int other_theta(input int cur);
    return (cur + int'($urandom_range(1, 63))) % 64;
  endfunction

  // scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    bus.px_idx = '0;
    bus.strip_busy = 1'b0;
    step(3);
    reset_n = 1'b1;
    for (int t = 0; t < 6; t++) begin theta = 6'(t); step(1); end
    n_checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    n_checks++; if (n_start !== 0) $display("FAIL reset_no_start: got %0d want 0", n_start); else n_pass++;
    n_checks++; if (bus.rom_addr !== '0) $display("FAIL reset_addr: got %0d want 0", bus.rom_addr); else n_pass++;
    n_checks++; if (bus.pixel_out !== 24'd0) $display("FAIL reset_pixel: got %h want 0", bus.pixel_out); else n_pass++;
    n_checks++; if (active_tex !== 4'd0) $display("FAIL reset_tex: got %0d want 0", active_tex); else n_pass++;
    n_checks++; if (tex_err !== 1'b0) $display("FAIL reset_err: got %b want 0", tex_err); else n_pass++;
    n_checks++; if (skip_count !== 16'd0) $display("FAIL reset_skip: got %0d want 0", skip_count); else n_pass++;
    n_checks++; if (rev_count !== 16'd0) $display("FAIL reset_rev: got %0d want 0", rev_count); else n_pass++;
  endtask

  task automatic test_launch();
    launch(3, 1'b1, 10, -1);
    n_checks++; if (int'(rev_count) !== m_rev) $display("FAIL rev_count: got %0d want %0d", rev_count, m_rev); else n_pass++;
    probe(7, "first_col");
    probe(60, "clamp");
    for (int i = 0; i < 3; i++) begin
      launch(other_theta(m_col), 1'b0, int'($urandom_range(1, 8)), -1);
      probe(int'($urandom_range(0, 63)), "rand_col");
    end
    launch(other_theta(m_col), 1'b0, 0, -1);
    probe(int'($urandom_range(0, 51)), "timeout_col");
  endtask

  task automatic test_bank_switch();
    strobe_req(2);
    launch(other_theta(m_col), 1'b0, 3, -1);
    n_checks++; if (int'(active_tex) !== m_active) $display("FAIL bank_hold: got %0d want %0d", active_tex, m_active); else n_pass++;
    launch(0, 1'b1, 5, -1);
    n_checks++; if (int'(active_tex) !== m_active) $display("FAIL bank_apply: got %0d want %0d", active_tex, m_active); else n_pass++;
    probe(0, "bank2");
    strobe_req(9);
    n_checks++; if (int'(tex_err) !== m_err) $display("FAIL tex_err: got %b want %0d", tex_err, m_err); else n_pass++;
    n_checks++; if (int'(active_tex) !== m_active) $display("FAIL err_keeps_bank: got %0d want %0d", active_tex, m_active); else n_pass++;
    launch(other_theta(m_col), 1'b1, 6, 1);
    n_checks++; if (int'(active_tex) !== m_active) $display("FAIL same_cycle_req: got %0d want %0d", active_tex, m_active); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      strobe_req(int'($urandom_range(0, 15)));
      launch(other_theta(m_col), 1'b1, int'($urandom_range(1, 6)), -1);
      n_checks++; if (int'(active_tex) !== m_active) $display("FAIL rand_bank: got %0d want %0d", active_tex, m_active); else n_pass++;
      n_checks++; if (int'(tex_err) !== m_err) $display("FAIL rand_err: got %b want %0d", tex_err, m_err); else n_pass++;
      probe(int'($urandom_range(0, 63)), "rand_bank");
    end
  endtask

  task automatic test_skip(input bit directed, input int first, input int k);
    int cur, s0;
    launch(first, 1'b1, -1, -1);
    step(2);
    cur = first;
    for (int i = 0; i < k; i++) begin
      cur = directed ? (first + 1 + i) % 64 : other_theta(cur);
      theta = 6'(cur);
      step(2);
    end
    m_skip += k - 1;
    n_checks++; if (int'(skip_count) !== m_skip) $display("FAIL skip_count: got %0d want %0d", skip_count, m_skip); else n_pass++;
    s0 = n_start;
    bus.strip_busy = 1'b0;
    for (int i = 0; i < 10 && n_start == s0; i++) step(1);
    m_col = cur;
    wait_state(ST_WAIT, 12);
    n_checks++; if (state_dbg !== ST_WAIT) $display("FAIL skip_frame_done: state %0d want %0d", state_dbg, ST_WAIT); else n_pass++;
    n_checks++; if (n_start - s0 !== 1) $display("FAIL skip_relaunch: got %0d starts want 1", n_start - s0); else n_pass++;
    probe(0, "skip_col");
  endtask

  task automatic test_reset_mid_stream();
    int s0;
    launch(other_theta(m_col), 1'b1, -1, -1);
    step(2);
    n_checks++; if (state_dbg !== ST_STREAM) $display("FAIL pre_reset_stream: state %0d want %0d", state_dbg, ST_STREAM); else n_pass++;
    reset_n = 1'b0;
    #1;
    m_active = 0; m_pend_v = 0; m_err = 0; m_skip = 0; m_rev = 0; m_col = 0;
    n_checks++; if (state_dbg !== ST_IDLE) $display("FAIL mid_reset_state: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    n_checks++; if (bus.strip_start !== 1'b0) $display("FAIL mid_reset_start: got %b want 0", bus.strip_start); else n_pass++;
    n_checks++; if (int'(skip_count) !== m_skip) $display("FAIL mid_reset_skip: got %0d want %0d", skip_count, m_skip); else n_pass++;
    n_checks++; if (int'(rev_count) !== m_rev) $display("FAIL mid_reset_rev: got %0d want %0d", rev_count, m_rev); else n_pass++;
    step(3);
    reset_n = 1'b1;
    bus.strip_busy = 1'b0;
    s0 = n_start;
    for (int i = 0; i < 6; i++) begin theta = 6'(other_theta(int'(theta))); step(1); end
    n_checks++; if (n_start !== s0) $display("FAIL no_start_after_reset: got %0d starts want 0", n_start - s0); else n_pass++;
    n_checks++; if (state_dbg !== ST_IDLE) $display("FAIL idle_after_reset: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    launch(int'($urandom_range(0, 63)), 1'b1, 4, -1);
    n_checks++; if (int'(rev_count) !== m_rev) $display("FAIL rev_after_reset: got %0d want %0d", rev_count, m_rev); else n_pass++;
  endtask

`ifdef HOLO_STALL_BLANK_EN
  task automatic test_stall();
    launch(other_theta(m_col), 1'b1, 3, -1);
    step(STALL + 10);
    n_checks++; if (bus.pixel_out !== 24'd0) $display("FAIL stall_blank: got %h want 0", bus.pixel_out); else n_pass++;
    n_checks++; if (state_dbg !== ST_IDLE) $display("FAIL stall_idle: got %0d want %0d", state_dbg, ST_IDLE); else n_pass++;
    launch(other_theta(m_col), 1'b1, 3, -1);
    probe(int'($urandom_range(1, 51)), "after_stall");
  endtask
`endif

  initial begin
    test_reset();
    test_launch();
    test_bank_switch();
    test_skip(1'b1, 4, 2);
    test_skip(1'b0, int'($urandom_range(0, 63)), int'($urandom_range(1, 5)));
    test_reset_mid_stream();
`ifdef HOLO_STALL_BLANK_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
